// File: rtl/inst_fetch_buf_pkg.sv
// Shared types for the instruction fetch buffer: the 4-wide fetch packet and
// the PC-tagged entry held in the buffer.
package inst_fetch_buf_pkg;
   localparam int FETCH_W     = 4;
   localparam int INST_W      = 32;
   localparam int ENTRY_PC_WD = 32;

   typedef logic [FETCH_W-1:0][INST_W-1:0] inst_set_t;

   typedef struct packed {
      logic [ENTRY_PC_WD-1:0] pc;
      logic [INST_W-1:0]      inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_slot_compact.sv
// Packs the valid slots of a fetch packet into the low output positions,
// tagging each with its PC, and reports how many were valid.
module fetch_slot_compact
   import inst_fetch_buf_pkg::*;
(
   input  logic [FETCH_W-1:0]              mask_i,
   input  inst_set_t                       inst_i,
   input  logic [ENTRY_PC_WD-1:0]          pc_i,
   output fetch_entry_t [FETCH_W-1:0]      ent_o,
   output logic [2:0]                      n_o
);
   logic [2:0] pos;

   // Running prefix count of set mask bits gives each valid slot its packed position.
   always_comb begin
      ent_o = '0;
      pos   = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         if (mask_i[i]) begin
            ent_o[pos[1:0]].pc   = pc_i + ENTRY_PC_WD'(4 * i);
            ent_o[pos[1:0]].inst = inst_i[i];
            pos                  = pos + 3'd1;
         end
      end
      n_o = pos;
   end
endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: compacts fetch packets into a circular entry array
// and presents up to DEQ_W oldest instructions to decode each cycle.
module inst_fetch_buf
   import inst_fetch_buf_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DEQ_W = 2,
   parameter int PC_WD = ENTRY_PC_WD
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       enq_valid_i,
   output logic                       enq_ready_o,
   input  inst_set_t                  enq_inst_i,
   input  logic [PC_WD-1:0]           enq_pc_i,
   input  logic [FETCH_W-1:0]         enq_mask_i,
   output logic [DEQ_W-1:0]           deq_valid_o,
   output logic [DEQ_W*INST_W-1:0]    deq_inst_o,
   output logic [DEQ_W*PC_WD-1:0]     deq_pc_o,
   input  logic [1:0]                 deq_cnt_i,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
   logic [PW-1:0]              count, deq_amt;
   logic                       enq_fire;
   fetch_entry_t               mem_q [DEPTH];
   fetch_entry_t               mem_d [DEPTH];
   fetch_entry_t [FETCH_W-1:0] cmp_ent;
   logic [2:0]                 cmp_n;

   fetch_slot_compact u_compact (
      .mask_i (enq_mask_i),
      .inst_i (enq_inst_i),
      .pc_i   (ENTRY_PC_WD'(enq_pc_i)),
      .ent_o  (cmp_ent),
      .n_o    (cmp_n)
   );

   // Pointers carry a wrap bit so full and empty are distinguishable.
   assign count       = tail_q - head_q;
   assign count_o     = count;
   assign enq_ready_o = (PW'(DEPTH) - count) >= PW'(FETCH_W);
   assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i & (|enq_mask_i);

   always_comb begin
      deq_amt = PW'(deq_cnt_i);
      if (deq_amt > PW'(DEQ_W)) deq_amt = PW'(DEQ_W);
      if (deq_amt > count)      deq_amt = count;
   end

   always_comb begin
      head_d = head_q + deq_amt;
      tail_d = tail_q + (enq_fire ? PW'(cmp_n) : '0);
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (enq_fire) begin
         for (int k = 0; k < FETCH_W; k++) begin
            if (3'(k) < cmp_n) mem_d[AW'(tail_q + PW'(k))] = cmp_ent[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Entry storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   for (genvar k = 0; k < DEQ_W; k++) begin : g_deq
      logic [AW-1:0] idx;
      assign idx                            = AW'(head_q + PW'(k));
      assign deq_valid_o[k]                 = count > PW'(k);
      assign deq_inst_o[k*INST_W +: INST_W] = mem_q[idx].inst;
      assign deq_pc_o[k*PC_WD +: PC_WD]     = PC_WD'(mem_q[idx].pc);
   end
endmodule

// File: tb/tb_inst_fetch_buf.sv
// Scoreboard bench for inst_fetch_buf: stimulus pushes expected entries,
// a negedge monitor compares the presented head entries and pops consumed ones.
module tb_inst_fetch_buf;
   import inst_fetch_buf_pkg::*;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst, flush_i, enq_valid_i, enq_ready_o;
   inst_set_t   enq_inst_i;
   logic [31:0] enq_pc_i;
   logic [3:0]  enq_mask_i;
   logic [1:0]  deq_valid_o;
   logic [63:0] deq_inst_o, deq_pc_o;
   logic [1:0]  deq_cnt_i;
   logic [4:0]  count_o;

   inst_fetch_buf dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .enq_valid_i(enq_valid_i),
      .enq_ready_o(enq_ready_o), .enq_inst_i(enq_inst_i), .enq_pc_i(enq_pc_i),
      .enq_mask_i(enq_mask_i), .deq_valid_o(deq_valid_o), .deq_inst_o(deq_inst_o),
      .deq_pc_o(deq_pc_o), .deq_cnt_i(deq_cnt_i), .count_o(count_o)
   );

   always #5 clk = ~clk;

   fetch_entry_t exp_q[$];
   int tests = 0;
   int fails = 0;
   inst_set_t pkt_a, pkt_b;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare visible head entries against the scoreboard, then retire consumed ones.
   always @(negedge clk) begin
      if (!rst) begin
         chk("mon_count", 64'(count_o), 64'(exp_q.size()));
         chk("mon_ready", 64'(enq_ready_o), 64'((DEPTH - exp_q.size()) >= 4));
         for (int k = 0; k < 2; k++) begin
            chk("mon_valid", 64'(deq_valid_o[k]), 64'(exp_q.size() > k));
            if (exp_q.size() > k) begin
               chk("mon_inst", 64'(deq_inst_o[k*32 +: 32]), 64'(exp_q[k].inst));
               chk("mon_pc", 64'(deq_pc_o[k*32 +: 32]), 64'(exp_q[k].pc));
            end
         end
         assert (int'(deq_cnt_i) <= exp_q.size()) else $error("deq_cnt_i exceeds occupancy");
         if (!flush_i)
            for (int k = 0; k < int'(deq_cnt_i); k++)
               if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   end

   // One cycle of stimulus: called at posedge+1, returns at the next posedge+1 with inputs idle.
   task automatic cyc(input bit v, input inst_set_t in, input logic [31:0] pc,
                      input logic [3:0] m, input logic [1:0] d, input bit f);
      logic [3:0] s;
      bit fire;
      enq_valid_i = v; enq_inst_i = in; enq_pc_i = pc; enq_mask_i = m;
      deq_cnt_i = d; flush_i = f;
      if (v) begin
         s = m;
         for (int i = 0; i < 4 && s != 0 && !s[0]; i++) s = s >> 1;
         assert (m != 4'b0 && ((s + 4'd1) & s) == 4'b0) else $error("illegal enq mask");
      end
      fire = v && enq_ready_o && !f;
      @(posedge clk);
      if (f) exp_q.delete();
      else if (fire)
         for (int i = 0; i < 4; i++)
            if (m[i]) exp_q.push_back('{pc: pc + 32'(4 * i), inst: in[i]});
      #1;
      enq_valid_i = 1'b0; deq_cnt_i = 2'd0; flush_i = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, pkt_a, 32'h0, 4'b0001, 2'd2, 1'b0);
   endtask

   task automatic skip_to_negedge();
      @(negedge clk);
   endtask

   task automatic back_to_drive();
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, limit 100000 time units");
      $fatal(1, "timeout");
   end

   initial begin
      pkt_a = {32'hD, 32'hC, 32'hB, 32'hA};
      pkt_b = {32'h44, 32'h33, 32'h22, 32'h11};
      rst = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0; enq_inst_i = '0;
      enq_pc_i = '0; enq_mask_i = 4'b0001; deq_cnt_i = 2'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      skip_to_negedge();
      chk("reset_count", 64'(count_o), 64'd0);
      chk("reset_valid", 64'(deq_valid_o), 64'd0);
      chk("reset_ready", 64'(enq_ready_o), 64'd1);
      back_to_drive();

      // Full packet, visible next cycle
      cyc(1'b1, pkt_a, 32'h1000, 4'b1111, 2'd0, 1'b0);
      skip_to_negedge();
      chk("t2_valid", 64'(deq_valid_o), 64'b11);
      chk("t2_inst", deq_inst_o, {32'hB, 32'hA});
      chk("t2_pc", deq_pc_o, {32'h1004, 32'h1000});
      chk("t2_count", 64'(count_o), 64'd4);
      back_to_drive();
      drain(2);

      // Partial masks
      cyc(1'b1, pkt_a, 32'h2000, 4'b0110, 2'd0, 1'b0);
      skip_to_negedge();
      chk("t3_count", 64'(count_o), 64'd2);
      chk("t3_pc", deq_pc_o, {32'h2008, 32'h2004});
      chk("t3_inst", deq_inst_o, {32'hC, 32'hB});
      back_to_drive();
      drain(1);
      cyc(1'b1, pkt_a, 32'h2000, 4'b1000, 2'd0, 1'b0);
      skip_to_negedge();
      chk("t3_single_valid", 64'(deq_valid_o), 64'b01);
      chk("t3_single_pc", 64'(deq_pc_o[31:0]), 64'h200C);
      chk("t3_single_inst", 64'(deq_inst_o[31:0]), 64'hD);
      back_to_drive();
      cyc(1'b0, pkt_a, 32'h0, 4'b0001, 2'd1, 1'b0);

      // Fill to 13, packet held until a dequeue frees room
      cyc(1'b1, pkt_b, 32'h3000, 4'b1111, 2'd0, 1'b0);
      cyc(1'b1, pkt_b, 32'h3010, 4'b1111, 2'd0, 1'b0);
      cyc(1'b1, pkt_b, 32'h3020, 4'b1111, 2'd0, 1'b0);
      cyc(1'b1, pkt_b, 32'h3030, 4'b0001, 2'd0, 1'b0);
      skip_to_negedge();
      chk("t4_count13", 64'(count_o), 64'd13);
      chk("t4_ready0", 64'(enq_ready_o), 64'd0);
      back_to_drive();
      cyc(1'b1, pkt_a, 32'hA000, 4'b1111, 2'd0, 1'b0);
      skip_to_negedge();
      chk("t4_held_count", 64'(count_o), 64'd13);
      back_to_drive();
      cyc(1'b1, pkt_a, 32'hA000, 4'b1111, 2'd1, 1'b0);
      skip_to_negedge();
      chk("t4_count12", 64'(count_o), 64'd12);
      chk("t4_ready1", 64'(enq_ready_o), 64'd1);
      back_to_drive();
      cyc(1'b1, pkt_a, 32'hA000, 4'b1111, 2'd0, 1'b0);
      skip_to_negedge();
      chk("t4_full", 64'(count_o), 64'd16);
      back_to_drive();
      drain(8);

      // Wrap: head/tail at index 8, advance tail to 14 then straddle the boundary
      cyc(1'b1, pkt_b, 32'h4000, 4'b0011, 2'd0, 1'b0);
      cyc(1'b1, pkt_b, 32'h4010, 4'b1111, 2'd0, 1'b0);
      cyc(1'b1, pkt_a, 32'h5000, 4'b1111, 2'd2, 1'b0);
      skip_to_negedge();
      chk("t5_count", 64'(count_o), 64'd8);
      back_to_drive();
      drain(2);
      skip_to_negedge();
      chk("t5_pc_lo", deq_pc_o, {32'h5004, 32'h5000});
      back_to_drive();
      drain(1);
      skip_to_negedge();
      chk("t5_pc_hi", deq_pc_o, {32'h500C, 32'h5008});
      chk("t5_inst_hi", deq_inst_o, {32'hD, 32'hC});
      back_to_drive();
      drain(1);

      // Flush dominates enq and deq
      cyc(1'b1, pkt_b, 32'h6000, 4'b1111, 2'd0, 1'b0);
      cyc(1'b1, pkt_b, 32'h6010, 4'b1111, 2'd0, 1'b0);
      cyc(1'b1, pkt_b, 32'h6020, 4'b0001, 2'd0, 1'b0);
      cyc(1'b1, pkt_a, 32'h6100, 4'b1111, 2'd2, 1'b1);
      skip_to_negedge();
      chk("t6_count", 64'(count_o), 64'd0);
      chk("t6_valid", 64'(deq_valid_o), 64'd0);
      chk("t6_ready", 64'(enq_ready_o), 64'd1);
      back_to_drive();
      cyc(1'b1, pkt_a, 32'h7000, 4'b1111, 2'd0, 1'b0);
      skip_to_negedge();
      chk("t6_after_pc", deq_pc_o, {32'h7004, 32'h7000});
      back_to_drive();

      // Async reset mid-stream at count 7, checked before any clock edge
      cyc(1'b1, pkt_b, 32'h8000, 4'b0111, 2'd0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t1_count", 64'(count_o), 64'd0);
      chk("t1_valid", 64'(deq_valid_o), 64'd0);
      chk("t1_ready", 64'(enq_ready_o), 64'd1);
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      skip_to_negedge();
      chk("t1_post_count", 64'(count_o), 64'd0);
      back_to_drive();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
